// File: rtl/exec_mem_slice_if.sv
// Control/data bundle between the decode stage (master) and the execute/memory/write-back
// slice (slave).
interface exec_mem_slice_if #(
  parameter int unsigned Bits    = 32,
  parameter int unsigned N       = 32,
  parameter int unsigned MemSize = 64
);
  localparam int unsigned PtrW = $clog2(N);

  logic [PtrW-1:0] rs1;
  logic [PtrW-1:0] rs2;
  logic [PtrW-1:0] rd;
  logic [Bits-1:0] imm;
  logic            reg_write;
  logic            alu_src;
  logic [1:0]      alu_op;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic [Bits-1:0] rd_data_1;
  logic [Bits-1:0] rd_data_2;
  logic [Bits-1:0] alu_result;
  logic            zero;
  logic [Bits-1:0] mem_read_data;
  logic [Bits-1:0] wb_data;

  modport master (
    output rs1, rs2, rd, imm, reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg,
    input  rd_data_1, rd_data_2, alu_result, zero, mem_read_data, wb_data
  );

  modport slave (
    input  rs1, rs2, rd, imm, reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg,
    output rd_data_1, rd_data_2, alu_result, zero, mem_read_data, wb_data
  );
endinterface

// File: rtl/exec_mem_slice.sv
// Execute/memory/write-back slice: register file, 4-function ALU, word data memory and
// the operand-B / write-back muxes of a single-cycle RISC-V datapath.
module exec_mem_slice #(
  parameter int unsigned Bits    = 32,
  parameter int unsigned N       = 32,
  parameter int unsigned MemSize = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  exec_mem_slice_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(MemSize);

  logic [Bits-1:0] r_regs [N];
  logic [Bits-1:0] r_mem  [MemSize];

  logic [Bits-1:0] w_rd_data_1;
  logic [Bits-1:0] w_rd_data_2;
  logic [Bits-1:0] w_op_b;
  logic [Bits-1:0] w_alu_result;
  logic [IdxW-1:0] w_mem_idx;
  logic [Bits-1:0] w_mem_read_data;
  logic [Bits-1:0] w_wb_data;

  // x0 reads as zero regardless of storage; no write-to-read bypass.
  always_comb begin
    w_rd_data_1 = (bus.rs1 == '0) ? '0 : r_regs[bus.rs1];
    w_rd_data_2 = (bus.rs2 == '0) ? '0 : r_regs[bus.rs2];
  end

  always_comb begin
    w_op_b       = bus.alu_src ? bus.imm : w_rd_data_2;
    w_alu_result = '0;
    unique case (bus.alu_op)
      2'b00: w_alu_result = w_rd_data_1 + w_op_b;
      2'b01: w_alu_result = w_rd_data_1 - w_op_b;
      2'b10: w_alu_result = w_rd_data_1 & w_op_b;
      2'b11: w_alu_result = w_rd_data_1 | w_op_b;
      default: w_alu_result = '0;
    endcase
  end

  // Byte address -> word index; low two bits and upper bits are dropped, so addresses wrap.
  assign w_mem_idx       = w_alu_result[IdxW+1:2];
  assign w_mem_read_data = bus.mem_read ? r_mem[w_mem_idx] : '0;
  assign w_wb_data       = bus.mem_to_reg ? w_mem_read_data : w_alu_result;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(N); i++) begin
        r_regs[i] <= '0;
      end
      for (int i = 0; i < int'(MemSize); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (bus.reg_write && (bus.rd != '0)) begin
        r_regs[bus.rd] <= w_wb_data;
      end
      if (bus.mem_write) begin
        r_mem[w_mem_idx] <= w_rd_data_2;
      end
    end
  end

  assign bus.rd_data_1     = w_rd_data_1;
  assign bus.rd_data_2     = w_rd_data_2;
  assign bus.alu_result    = w_alu_result;
  assign bus.zero          = (w_alu_result == '0);
  assign bus.mem_read_data = w_mem_read_data;
  assign bus.wb_data       = w_wb_data;
endmodule

// File: tb/tb_exec_mem_slice.sv
// Directed plus random bench for exec_mem_slice against an array-based reference model.
module tb_exec_mem_slice;
  localparam int unsigned Bits    = 32;
  localparam int unsigned N       = 32;
  localparam int unsigned MemSize = 64;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  exec_mem_slice_if #(.Bits(Bits), .N(N), .MemSize(MemSize)) bus ();

  exec_mem_slice #(.Bits(Bits), .N(N), .MemSize(MemSize)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_regs [N];
  logic [31:0] m_mem  [MemSize];

  // Expected values for the currently applied inputs.
  logic [31:0] e_a, e_b, e_alu, e_mrd, e_wb;
  int          e_idx;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input int rd, input logic [31:0] imm,
                       input bit rw, input bit src, input int op, input bit mr, input bit mw,
                       input bit m2r);
    bus.rs1 = 5'(rs1);
    bus.rs2 = 5'(rs2);
    bus.rd = 5'(rd);
    bus.imm = imm;
    bus.reg_write = rw;
    bus.alu_src = src;
    bus.alu_op = 2'(op);
    bus.mem_read = mr;
    bus.mem_write = mw;
    bus.mem_to_reg = m2r;
    #1;
  endtask

  // Reference: registers/memory as plain arrays, ALU as arithmetic on the specified rules.
  task automatic model_eval();
    logic [31:0] b_reg;
    e_a   = (bus.rs1 == 0) ? 32'd0 : m_regs[bus.rs1];
    b_reg = (bus.rs2 == 0) ? 32'd0 : m_regs[bus.rs2];
    e_b   = b_reg;
    case (bus.alu_op)
      2'd0: e_alu = e_a + (bus.alu_src ? bus.imm : b_reg);
      2'd1: e_alu = e_a - (bus.alu_src ? bus.imm : b_reg);
      2'd2: e_alu = e_a & (bus.alu_src ? bus.imm : b_reg);
      default: e_alu = e_a | (bus.alu_src ? bus.imm : b_reg);
    endcase
    e_idx = int'((e_alu % (4 * MemSize)) / 4);
    e_mrd = bus.mem_read ? m_mem[e_idx] : 32'd0;
    e_wb  = bus.mem_to_reg ? e_mrd : e_alu;
  endtask

  task automatic check_all(input string tag);
    model_eval();
    expect_eq({tag, ".rd1"}, bus.rd_data_1, e_a);
    expect_eq({tag, ".rd2"}, bus.rd_data_2, e_b);
    expect_eq({tag, ".alu"}, bus.alu_result, e_alu);
    expect_eq({tag, ".zero"}, 32'(bus.zero), 32'(e_alu == 0));
    expect_eq({tag, ".mrd"}, bus.mem_read_data, e_mrd);
    expect_eq({tag, ".wb"}, bus.wb_data, e_wb);
  endtask

  // Advance one edge, updating the model from the inputs applied before it.
  task automatic tick();
    model_eval();
    @(posedge i_clk);
    if (!i_rst) begin
      for (int i = 0; i < int'(N); i++) m_regs[i] = '0;
      for (int i = 0; i < int'(MemSize); i++) m_mem[i] = '0;
    end else begin
      if (bus.mem_write) m_mem[e_idx] = e_b;
      if (bus.reg_write && bus.rd != 0) m_regs[bus.rd] = e_wb;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) m_regs[i] = 'x;
    for (int i = 0; i < int'(MemSize); i++) m_mem[i] = 'x;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;

    drive(5, 31, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("reset");
    expect_eq("reset.alu_const", bus.alu_result, 32'd0);
    expect_eq("reset.zero_const", 32'(bus.zero), 32'd1);

    drive(0, 0, 1, 7, 1, 1, 0, 0, 0, 0);
    check_all("li_x1");
    tick();
    drive(0, 0, 2, 5, 1, 1, 0, 0, 0, 0);
    check_all("li_x2");
    tick();

    drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("add");
    expect_eq("add.const", bus.alu_result, 32'd12);
    drive(1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    expect_eq("sub.const", bus.alu_result, 32'd2);
    drive(1, 2, 0, 0, 0, 0, 2, 0, 0, 0);
    expect_eq("and.const", bus.alu_result, 32'd5);
    drive(1, 2, 0, 0, 0, 0, 3, 0, 0, 0);
    expect_eq("or.const", bus.alu_result, 32'd7);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    check_all("sub_self");
    expect_eq("sub_self.zero", 32'(bus.zero), 32'd1);
    drive(2, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    expect_eq("sub_neg.const", bus.alu_result, 32'hFFFF_FFFE);

    drive(0, 1, 0, 8, 0, 1, 0, 0, 1, 0);
    check_all("store");
    tick();
    drive(0, 0, 3, 8, 1, 1, 0, 1, 1'b0, 1);
    check_all("load");
    expect_eq("load.mrd_const", bus.mem_read_data, 32'd7);
    tick();
    drive(3, 0, 0, 8, 0, 1, 0, 0, 0, 1);
    expect_eq("load.x3", bus.rd_data_1, 32'd7);
    expect_eq("noread.mrd", bus.mem_read_data, 32'd0);
    expect_eq("noread.wb", bus.wb_data, 32'd0);

    drive(0, 0, 0, 32'hFFFF, 1, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_eq("x0.hardwired", bus.rd_data_1, 32'd0);

    drive(4, 0, 4, 9, 1, 1, 0, 0, 0, 0);
    expect_eq("x4.before_edge", bus.rd_data_1, 32'd0);
    tick();
    drive(4, 0, 0, 9, 0, 1, 0, 0, 0, 0);
    expect_eq("x4.after_edge", bus.rd_data_1, 32'd9);

    drive(1, 1, 5, 8, 1, 1, 0, 0, 1, 0);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    drive(1, 4, 0, 8, 0, 1, 0, 1, 0, 1);
    check_all("midrst");
    expect_eq("midrst.x1", bus.rd_data_1, 32'd0);
    expect_eq("midrst.mem2", bus.mem_read_data, 32'd0);
    drive(5, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_eq("midrst.x5", bus.rd_data_1, 32'd0);

    // Random traffic; small immediates keep addresses landing on stored words.
    for (int t = 0; t < 400; t++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm,
            1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
            1'($urandom));
      check_all("rand");
      i_rst = ($urandom_range(0, 59) != 0);
      tick();
      i_rst = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
